// File: rtl/mdu_iter.sv
// mdu_iter: iterative RISC-V M-extension multiply/divide unit (shift-add / restoring divide).
// Define MDU_FAST_MUL_EN to compute multiplies in one cycle; divides stay iterative.
`timescale 1ns/1ps
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_mb;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  function automatic logic [XLEN-1:0] cneg(input logic n, input logic [XLEN-1:0] v);
    cneg = n ? ((~v) + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic n, input logic [2*XLEN-1:0] v);
    cneg2 = n ? ((~v) + (2*XLEN)'(1)) : v;
  endfunction

  function automatic logic [XLEN-1:0] sel_result(input logic [2:0] op,
                                                 input logic [2*XLEN-1:0] prod,
                                                 input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] rem);
    case (op)
      3'b000:                 sel_result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: sel_result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         sel_result = quo;
      default:                sel_result = rem;
    endcase
  endfunction

  logic            w_sgn_a;
  logic            w_sgn_b;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_ma;
  logic [XLEN-1:0] w_mb;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_special;

  // Operand decode: signedness, magnitudes and the divide corner cases.
  always_comb begin
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
      3'b010:                         begin w_sgn_a = 1'b1; w_sgn_b = 1'b0; end
      default:                        begin w_sgn_a = 1'b0; w_sgn_b = 1'b0; end
    endcase
    w_sa   = w_sgn_a & op_a[XLEN-1];
    w_sb   = w_sgn_b & op_b[XLEN-1];
    w_ma   = cneg(w_sa, op_a);
    w_mb   = cneg(w_sb, op_b);
    w_div0 = funct3[2] && (op_b == '0);
    w_ovf  = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    w_special = '0;
    if (w_div0) begin
      w_special = funct3[1] ? op_a : '1;
    end else if (w_ovf) begin
      w_special = funct3[1] ? '0 : op_a;
    end else begin
      w_special = '0;
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_mag;
  logic [XLEN-1:0]   w_fast;

  // Single-cycle product of magnitudes, sign-corrected before selection.
  always_comb begin
    w_fast_mag = {{XLEN{1'b0}}, w_ma} * {{XLEN{1'b0}}, w_mb};
    w_fast     = sel_result(funct3, cneg2(w_sa ^ w_sb, w_fast_mag), '0, '0);
  end
`endif

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_trial;
  logic [XLEN-1:0]   w_hi_nx;
  logic [XLEN-1:0]   w_lo_nx;
  logic [XLEN-1:0]   w_final;

  // One iteration step; {hi,lo} is partial product/multiplier or remainder/quotient.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mb} : {(XLEN+1){1'b0}});
    w_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_mb};
    if (r_op[2]) begin
      if (!w_trial[XLEN]) begin
        w_hi_nx = w_trial[XLEN-1:0];
        w_lo_nx = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nx = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
        w_lo_nx = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_nx = w_sum[XLEN:1];
      w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
    end
    w_final = sel_result(r_op, cneg2(r_neg_q, {w_hi_nx, w_lo_nx}),
                         cneg(r_neg_q, w_lo_nx), cneg(r_neg_r, w_hi_nx));
  end

  // Control FSM; result and done are written on the way into FINISH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= 3'b000;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mb     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (kill) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op    <= funct3;
            r_mb    <= w_mb;
            r_hi    <= '0;
            r_lo    <= w_ma;
            r_cnt   <= '0;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_busy  <= 1'b1;
            if (w_div0 || w_ovf) begin
              r_result <= w_special;
              r_done   <= 1'b1;
              r_state  <= S_FINISH;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!funct3[2]) begin
              r_result <= w_fast;
              r_done   <= 1'b1;
              r_state  <= S_FINISH;
            end
`endif
            else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_result <= w_final;
            r_done   <= 1'b1;
            r_state  <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
